// File: rtl/y86_mem_arbiter.sv
// y86_mem_arbiter: round-robin arbiter sharing the y86 memory bus between two
// masters. One transaction at a time. The bus is held for LAT cycles, then a
// one-cycle done pulse is sent to the owning requester.
module y86_mem_arbiter #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata,
    output logic        owner,
    output logic [31:0] bus_A,
    output logic [31:0] bus_out,
    output logic        bus_WE,
    output logic        bus_RE,
    input  logic [31:0] bus_in
);

    localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    if (LAT < 1) begin : g_lat_check
        $error("y86_mem_arbiter: LAT must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             winner;

    // Pick the winner. A lone requester wins. On a tie, the requester that
    // did not own the previous transaction wins.
    always_comb begin
        winner = (req0 && req1) ? ~owner : req1;
    end

    // Arbiter FSM. The bus outputs double as the latched transaction fields,
    // so every output is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            rdata   <= '0;
            owner   <= 1'b1;
            bus_A   <= '0;
            bus_out <= '0;
            bus_WE  <= 1'b0;
            bus_RE  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    if (req0 || req1) begin
                        owner   <= winner;
                        cnt     <= CNT_LOAD;
                        gnt0    <= ~winner;
                        gnt1    <= winner;
                        bus_A   <= winner ? addr1  : addr0;
                        bus_out <= winner ? wdata1 : wdata0;
                        bus_WE  <= winner ? we1    : we0;
                        bus_RE  <= winner ? ~we1   : ~we0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    gnt0 <= 1'b0;
                    gnt1 <= 1'b0;
                    if (cnt == '0) begin
                        if (bus_RE) begin
                            rdata <= bus_in;
                        end
                        bus_A   <= '0;
                        bus_out <= '0;
                        bus_WE  <= 1'b0;
                        bus_RE  <= 1'b0;
                        done0   <= ~owner;
                        done1   <= owner;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
